tiny_cpu_core: RTL and testbench

Parametrised second-generation tiny CPU core: a multicycle accumulator-free 3-operand machine with a loadable instruction RAM, an 8-entry register file, branches, and a ready/valid output port. It sits under the Tiny Tapeout top-level wrapper, which maps pins onto the loader, control and I/O ports. Compared with the first-generation core it adds a data width parameter, an instruction memory depth parameter, a start/halt control, conditional branches and output backpressure.

---
 rtl/tiny_cpu_pkg.sv | 41 ++++
 rtl/tiny_cpu_alu.sv | 34 +++
 rtl/tiny_cpu_core.sv | 131 +++++++++++++
 tb/tb_tiny_cpu_core.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared encodings for the tiny CPU: FSM states, opcodes, ALU functions and
// instruction field positions.
package tiny_cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [2:0] OP_ALU  = 3'd0;
  localparam logic [2:0] OP_ALUI = 3'd1;
  localparam logic [2:0] OP_LI   = 3'd2;
  localparam logic [2:0] OP_IN   = 3'd3;
  localparam logic [2:0] OP_OUT  = 3'd4;
  localparam logic [2:0] OP_BR   = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;
  localparam logic [2:0] FN_SLL = 3'd5;
  localparam logic [2:0] FN_SRL = 3'd6;
  localparam logic [2:0] FN_MUL = 3'd7;

  localparam int F_OP_LSB   = 13;
  localparam int F_RD_LSB   = 10;
  localparam int F_RS1_LSB  = 7;
  localparam int F_RS2_LSB  = 4;
  localparam int F_FUNC_LSB = 0;
  localparam int F_BR_NZ    = 12;

  function automatic logic [2:0] field3(input logic [15:0] word, input int lsb);
    return word[lsb +: 3];
  endfunction

endpackage

// File: rtl/tiny_cpu_alu.sv
// Combinational ALU; every result wraps to DATA_WIDTH bits and shifts use only
// the low log2(DATA_WIDTH) bits of b.
module tiny_cpu_alu
  import tiny_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            func,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SW = $clog2(DATA_WIDTH);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    result = '0;
    case (func)
      FN_ADD:  result = a + b;
      FN_SUB:  result = a - b;
      FN_AND:  result = a & b;
      FN_OR:   result = a | b;
      FN_XOR:  result = a ^ b;
      FN_SLL:  result = a << shamt;
      FN_SRL:  result = a >> shamt;
      FN_MUL:  result = a * b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/tiny_cpu_core.sv
// Multicycle 3-operand CPU core: loadable instruction RAM, 8-entry register
// file, branches and a ready/valid output port.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   FETCH | latch instruction at pc
//   EXEC  | commit rd/pc; OUT waits here for the handshake
//   HALT  | stopped by HALT, start restarts from pc 0
module tiny_cpu_core
  import tiny_cpu_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  IMEM_DEPTH = 16,
  localparam int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [15:0]           prog_data,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  halted,
  output logic [AW-1:0]         pc_dbg,
  output logic [1:0]            state_dbg
);

  logic [15:0]           imem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0] regs [8];
  logic [15:0]           ir;
  logic [AW-1:0]         pc;
  state_t                state;

  logic [2:0]            op, rd, rs1, rs2, func;
  logic [DATA_WIDTH-1:0] op_a, op_b, alu_y, wb_data;
  logic                  br_taken;

  always_comb begin
    op       = field3(ir, F_OP_LSB);
    rd       = field3(ir, F_RD_LSB);
    rs1      = field3(ir, F_RS1_LSB);
    rs2      = field3(ir, F_RS2_LSB);
    func     = field3(ir, F_FUNC_LSB);
    op_a     = regs[rs1];
    op_b     = (op == OP_ALUI) ? DATA_WIDTH'(ir[6:3]) : regs[rs2];
    br_taken = (op_a == '0) ^ ir[F_BR_NZ];
    wb_data  = alu_y;
    case (op)
      OP_LI:   wb_data = DATA_WIDTH'({8'h00, ir[7:0]});
      OP_IN:   wb_data = in_data;
      default: wb_data = alu_y;
    endcase
  end

  tiny_cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .func   (func),
    .result (alu_y)
  );

  // Instruction RAM is deliberately left out of reset so it can be a plain memory.
  always_ff @(posedge clk) begin
    if (prog_we) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (!prog_we) begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc     <= '0;
            state  <= S_FETCH;
            halted <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_OUT: begin
              // First EXEC cycle presents the data; later cycles wait for acceptance.
              if (!out_valid) begin
                out_data  <= op_a;
                out_valid <= 1'b1;
              end else if (out_ready) begin
                out_valid <= 1'b0;
                pc        <= pc + AW'(1);
                state     <= S_FETCH;
              end
            end
            OP_BR: begin
              pc    <= br_taken ? ir[AW-1:0] : pc + AW'(1);
              state <= S_FETCH;
            end
            OP_JMP: begin
              pc    <= ir[AW-1:0];
              state <= S_FETCH;
            end
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: begin
              if (rd != 3'd0) regs[rd] <= wb_data;
              pc    <= pc + AW'(1);
              state <= S_FETCH;
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pc_dbg    = pc;
  assign state_dbg = state;

endmodule

// File: tb/tb_tiny_cpu_core.sv
// Scoreboard bench: each program's expected OUT stream is queued up front and a
// monitor pops one entry per accepted output.
module tb_tiny_cpu_core;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          halted;
  logic [AW-1:0] pc_dbg;
  logic [1:0]    state_dbg;

  tiny_cpu_core #(.DATA_WIDTH(DW), .IMEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted),
    .pc_dbg    (pc_dbg),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          vcnt  = 0;
  int          exp_q[$];
  logic [15:0] prog [DEPTH];

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (out_valid) vcnt++;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_unexpected: got out_data %0d, required no output", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(out_data), e);
        end
      end
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int s1, input int low7);
    logic [15:0] w;
    w = {3'(op), 3'(rd), 3'(s1), 7'(low7)};
    return w;
  endfunction
  function automatic logic [15:0] e_alu(input int rd, input int s1, input int s2, input int f);
    return enc(0, rd, s1, (s2 << 4) | f);
  endfunction
  function automatic logic [15:0] e_alui(input int rd, input int s1, input int imm, input int f);
    return enc(1, rd, s1, (imm << 3) | f);
  endfunction
  function automatic logic [15:0] e_li(input int rd, input int imm);
    logic [15:0] w;
    w = {3'd2, 3'(rd), 2'b00, 8'(imm)};
    return w;
  endfunction
  function automatic logic [15:0] e_out(input int s1);
    return enc(4, 0, s1, 0);
  endfunction
  function automatic logic [15:0] e_br(input int nz, input int s1, input int t);
    return enc(5, nz * 4, s1, t);
  endfunction
  function automatic logic [15:0] e_halt();
    return enc(7, 0, 0, 0);
  endfunction

  // Reference ALU on plain integers, results reduced mod 256.
  function automatic int alu_ref(input int f, input int a, input int b);
    case (f)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return (a << (b % 8)) % 256;
      6:       return a >> (b % 8);
      default: return (a * b) % 256;
    endcase
  endfunction

  // Instruction-level interpreter starting from cleared registers at pc 0.
  task automatic model_run(input int ind);
    int r[8];
    int pc, op, rd, s1, s2, f;
    logic [15:0] w;
    for (int i = 0; i < 8; i++) r[i] = 0;
    pc = 0;
    for (int step = 0; step < 300; step++) begin
      w  = prog[pc];
      op = int'(w[15:13]); rd = int'(w[12:10]); s1 = int'(w[9:7]);
      s2 = int'(w[6:4]);   f  = int'(w[2:0]);
      if (op == 7) break;
      case (op)
        0: r[rd] = alu_ref(f, r[s1], r[s2]);
        1: r[rd] = alu_ref(f, r[s1], int'(w[6:3]));
        2: r[rd] = int'(w[7:0]);
        3: r[rd] = ind;
        4: exp_q.push_back(r[s1]);
        default: ;
      endcase
      r[0] = 0;
      if (op == 6 || (op == 5 && ((r[s1] == 0) != w[12]))) pc = int'(w[3:0]);
      else pc = (pc + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) write_word(i, prog[i]);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = e_halt();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int pct);
    for (int c = 0; c < 600 && !halted; c++) begin
      out_ready = ($urandom_range(99) < pct);
      tick();
    end
    check("halted", int'(halted), 1);
    check("state_halt", int'(state_dbg), 3);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_valid(input string nm);
    int ok = 0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid) begin ok = 1; break; end
      tick();
    end
    check(nm, ok, 1);
  endtask

  initial begin
    int v0, ok, s0, p0, k, rd, s1, s2, t;
    fork
      monitor();
    join_none

    reset_dut();
    check("rst_state", int'(state_dbg), 0);
    check("rst_pc", int'(pc_dbg), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_halted", int'(halted), 0);

    // 5 * 3 = 15, single-cycle valid with ready held high
    clear_prog();
    prog[0] = e_li(1, 5); prog[1] = e_li(2, 3); prog[2] = e_alu(3, 1, 2, 7);
    prog[3] = e_out(3);
    load_prog();
    exp_q.push_back(15);
    v0 = vcnt;
    start_pulse();
    wait_halt(100);
    check("valid_one_cycle", vcnt - v0, 1);
    // registers survive a restart from HALT
    write_word(0, e_out(3));
    write_word(1, e_halt());
    exp_q.push_back(15);
    start_pulse();
    wait_halt(100);

    // countdown loop
    reset_dut();
    clear_prog();
    prog[0] = e_li(1, 3); prog[1] = e_alui(1, 1, 1, 1); prog[2] = e_out(1);
    prog[3] = e_br(1, 1, 1);
    load_prog();
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
    start_pulse();
    wait_halt(100);

    // width wrap, shift amount masking, x0 hardwired
    reset_dut();
    clear_prog();
    prog[0] = e_li(1, 200); prog[1] = e_li(2, 100); prog[2] = e_alu(3, 1, 2, 0);
    prog[3] = e_out(3); prog[4] = e_li(4, 9); prog[5] = e_li(5, 8'h81);
    prog[6] = e_alu(6, 5, 4, 5); prog[7] = e_out(6); prog[8] = e_li(0, 77);
    prog[9] = e_out(0);
    load_prog();
    exp_q.push_back(44); exp_q.push_back(2); exp_q.push_back(0);
    start_pulse();
    wait_halt(70);

    // backpressure: valid held, pc frozen
    reset_dut();
    clear_prog();
    prog[0] = e_li(1, 8'h5A); prog[1] = e_out(1);
    load_prog();
    exp_q.push_back(8'h5A);
    start_pulse();
    wait_valid("bp_valid_rise");
    for (int c = 0; c < 5; c++) begin
      check("bp_valid_held", int'(out_valid), 1);
      check("bp_pc_frozen", int'(pc_dbg), 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_valid_drop", int'(out_valid), 0);
    check("bp_pc_advance", int'(pc_dbg), 2);
    check("bp_state_fetch", int'(state_dbg), 1);
    wait_halt(100);

    // no HALT: pc wraps, prog_we stalls one cycle, start ignored while running
    reset_dut();
    for (int i = 0; i < DEPTH; i++) prog[i] = e_li(1, i);
    load_prog();
    start_pulse();
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      if (pc_dbg == 4'd15 && state_dbg == 2'd2) begin ok = 1; break; end
      tick();
    end
    check("reach_pc15", ok, 1);
    tick();
    check("pc_wrap", int'(pc_dbg), 0);
    s0 = int'(state_dbg); p0 = int'(pc_dbg);
    write_word(3, e_li(1, 3));
    check("we_hold_state", int'(state_dbg), s0);
    check("we_hold_pc", int'(pc_dbg), p0);
    tick();
    check("we_resume_state", int'(state_dbg), (s0 == 1) ? 2 : 1);
    tick();
    check("run_fetch_pc1", int'(pc_dbg), 1);
    start_pulse();
    check("start_ignored_pc", int'(pc_dbg), 1);
    check("start_ignored_state", int'(state_dbg), 2);

    // reset while an OUT is waiting
    reset_dut();
    clear_prog();
    prog[0] = e_li(1, 9); prog[1] = e_out(1);
    load_prog();
    start_pulse();
    wait_valid("rst_valid_rise");
    #2 rst = 1'b1;
    #1;
    check("abort_valid", int'(out_valid), 0);
    check("abort_state", int'(state_dbg), 0);
    check("abort_pc", int'(pc_dbg), 0);
    check("abort_out_data", int'(out_data), 0);
    tick();
    rst = 1'b0;

    // random straight-line programs with forward branches, random backpressure
    for (int n = 0; n < 20; n++) begin
      reset_dut();
      for (int i = 0; i < DEPTH - 1; i++) begin
        k = $urandom_range(9); rd = $urandom_range(7);
        s1 = $urandom_range(7); s2 = $urandom_range(7);
        t = $urandom_range(DEPTH - 1, i + 1);
        case (k)
          0, 1: prog[i] = e_alu(rd, s1, s2, $urandom_range(7));
          2:    prog[i] = e_alui(rd, s1, $urandom_range(15), $urandom_range(7));
          3:    prog[i] = e_li(rd, $urandom_range(255));
          4:    prog[i] = enc(3, rd, 0, 0);
          5, 6: prog[i] = e_out(s1);
          7:    prog[i] = e_br($urandom_range(1), s1, t);
          8:    prog[i] = enc(6, 0, 0, t);
          default: prog[i] = e_li(rd, $urandom_range(255));
        endcase
      end
      prog[DEPTH-1] = e_halt();
      in_data = DW'($urandom_range(255));
      load_prog();
      model_run(int'(in_data));
      start_pulse();
      wait_halt($urandom_range(100, 30));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
